// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings, state enum and helpers for the memory access sequencer
package mem_ctrl_pkg;

    localparam int LOAD_W = 64;

    localparam logic [3:0] OP_LDSB   = 4'd0;
    localparam logic [3:0] OP_LDSH   = 4'd1;
    localparam logic [3:0] OP_LDUB   = 4'd2;
    localparam logic [3:0] OP_LDUH   = 4'd3;
    localparam logic [3:0] OP_LD     = 4'd4;
    localparam logic [3:0] OP_LDD    = 4'd5;
    localparam logic [3:0] OP_STB    = 4'd6;
    localparam logic [3:0] OP_STH    = 4'd7;
    localparam logic [3:0] OP_ST     = 4'd8;
    localparam logic [3:0] OP_STD    = 4'd9;
    localparam logic [3:0] OP_LDSTUB = 4'd10;
    localparam logic [3:0] OP_SWAP   = 4'd11;

    localparam logic [1:0] MEM_RD = 2'b00;
    localparam logic [1:0] MEM_WB = 2'b01;
    localparam logic [1:0] MEM_WH = 2'b10;
    localparam logic [1:0] MEM_WW = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_RD1, S_CAP1, S_RD2, S_CAP2, S_WR1, S_WR2, S_DONE
    } state_t;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] sz;
        case (op)
            OP_LDSB, OP_LDUB, OP_STB, OP_LDSTUB: sz = SZ_BYTE;
            OP_LDSH, OP_LDUH, OP_STH:            sz = SZ_HALF;
            OP_LD, OP_ST, OP_SWAP:               sz = SZ_WORD;
            default:                             sz = SZ_DWORD;
        endcase
        return sz;
    endfunction

    // Illegal opcode or address not aligned to the access size.
    function automatic logic op_trap(input logic [3:0] op, input logic [2:0] addr);
        logic t;
        if (op > OP_SWAP) begin
            t = 1'b1;
        end else begin
            case (op_size(op))
                SZ_HALF:  t = addr[0];
                SZ_WORD:  t = (addr[1:0] != 2'b00);
                SZ_DWORD: t = (addr != 3'b000);
                default:  t = 1'b0;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// rtl/mem_access_ctrl_load_align.sv - big-endian lane select with sign/zero extension
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = word[31:24];
            2'd1:    byte_lane = word[23:16];
            2'd2:    byte_lane = word[15:8];
            default: byte_lane = word[7:0];
        endcase
        half_lane = addr[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store/atomic sequencer between the CPU control unit and data RAM
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [3:0]        CpuOp,
    input  logic [ADDR_W-1:0] Address,
    input  logic [63:0]       StoreData,
    output logic [LOAD_W-1:0] LoadData,
    output logic              Done,
    output logic              Trap,
    output logic              Busy,
    output logic              Mem_Enable,
    output logic [1:0]        Mem_Op,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_WrData,
    input  logic [31:0]       Mem_RdData
);

    state_t            state;
    logic [3:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       sdata_r;
    logic [31:0]       word_r;
    logic [31:0]       aligned;
    logic              atomic;

    assign atomic = (op_r == OP_LDSTUB) || (op_r == OP_SWAP);

    load_align u_align (
        .word     (Mem_RdData),
        .addr     (addr_r[1:0]),
        .size     (op_size(op_r)),
        .sign_ext ((op_r == OP_LDSB) || (op_r == OP_LDSH)),
        .result   (aligned)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            op_r        <= 4'd0;
            addr_r      <= '0;
            sdata_r     <= 32'd0;
            word_r      <= 32'd0;
            LoadData    <= '0;
            Done        <= 1'b0;
            Trap        <= 1'b0;
            Busy        <= 1'b0;
            Mem_Enable  <= 1'b0;
            Mem_Op      <= MEM_RD;
            Mem_Address <= '0;
            Mem_WrData  <= 32'd0;
        end else begin
            Done       <= 1'b0;
            Mem_Enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_r    <= CpuOp;
                        addr_r  <= Address;
                        sdata_r <= StoreData[31:0];
                        Busy    <= 1'b1;
                        if (op_trap(CpuOp, Address[2:0])) begin
                            state    <= S_DONE;
                            Done     <= 1'b1;
                            Trap     <= 1'b1;
                            LoadData <= '0;
                        end else if (CpuOp inside {OP_STB, OP_STH, OP_ST, OP_STD}) begin
                            state       <= S_WR1;
                            Mem_Enable  <= 1'b1;
                            Mem_Address <= Address;
                            case (CpuOp)
                                OP_STB: begin
                                    Mem_Op     <= MEM_WB;
                                    Mem_WrData <= {24'd0, StoreData[7:0]};
                                end
                                OP_STH: begin
                                    Mem_Op     <= MEM_WH;
                                    Mem_WrData <= {16'd0, StoreData[15:0]};
                                end
                                OP_ST: begin
                                    Mem_Op     <= MEM_WW;
                                    Mem_WrData <= StoreData[31:0];
                                end
                                default: begin
                                    Mem_Op     <= MEM_WW;
                                    Mem_WrData <= StoreData[63:32];
                                end
                            endcase
                        end else begin
                            state       <= S_RD1;
                            Mem_Enable  <= 1'b1;
                            Mem_Op      <= MEM_RD;
                            Mem_Address <= {Address[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                S_RD1: state <= S_CAP1;
                S_CAP1: begin
                    if (op_r == OP_LDD) begin
                        word_r      <= Mem_RdData;
                        state       <= S_RD2;
                        Mem_Enable  <= 1'b1;
                        Mem_Op      <= MEM_RD;
                        Mem_Address <= addr_r + ADDR_W'(4);
                    end else if (atomic) begin
                        // Old value is kept until the write completes, then returned.
                        word_r      <= aligned;
                        state       <= S_WR1;
                        Mem_Enable  <= 1'b1;
                        Mem_Address <= addr_r;
                        Mem_Op      <= (op_r == OP_LDSTUB) ? MEM_WB : MEM_WW;
                        Mem_WrData  <= (op_r == OP_LDSTUB) ? 32'h0000_00FF : sdata_r;
                    end else begin
                        state    <= S_DONE;
                        Done     <= 1'b1;
                        LoadData <= {32'd0, aligned};
                    end
                end
                S_RD2: state <= S_CAP2;
                S_CAP2: begin
                    state    <= S_DONE;
                    Done     <= 1'b1;
                    LoadData <= {word_r, Mem_RdData};
                end
                S_WR1: begin
                    if (op_r == OP_STD) begin
                        state       <= S_WR2;
                        Mem_Enable  <= 1'b1;
                        Mem_Address <= addr_r + ADDR_W'(4);
                        Mem_WrData  <= sdata_r;
                    end else begin
                        state    <= S_DONE;
                        Done     <= 1'b1;
                        LoadData <= atomic ? {32'd0, word_r} : '0;
                    end
                end
                S_WR2: begin
                    state    <= S_DONE;
                    Done     <= 1'b1;
                    LoadData <= '0;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Trap  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench with a big-endian byte RAM model
module tb_mem_access_ctrl;

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct packed {
        logic [63:0] data;
        logic        trap;
        logic [7:0]  lat;
        logic        chk_data;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  CpuOp = 4'd0;
    logic [7:0]  Address = 8'd0;
    logic [63:0] StoreData = 64'd0;
    logic [63:0] LoadData;
    logic        Done, Trap, Busy, Mem_Enable;
    logic [1:0]  Mem_Op;
    logic [7:0]  Mem_Address;
    logic [31:0] Mem_WrData;
    logic [31:0] Mem_RdData = 32'hA5A5_A5A5;

    mem_access_ctrl #(.ADDR_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .CpuOp(CpuOp), .Address(Address),
        .StoreData(StoreData), .LoadData(LoadData), .Done(Done), .Trap(Trap), .Busy(Busy),
        .Mem_Enable(Mem_Enable), .Mem_Op(Mem_Op), .Mem_Address(Mem_Address),
        .Mem_WrData(Mem_WrData), .Mem_RdData(Mem_RdData)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   done_cnt = 0;
    acc_t exp_acc[$];
    res_t exp_res[$];
    logic [7:0]  mem [0:255];
    logic [31:0] rd_pend;
    logic        rd_arm = 1'b0;
    logic [7:0]  wbase;
    acc_t a;
    res_t r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (rd_arm) begin
            Mem_RdData <= rd_pend;
            rd_arm = 1'b0;
        end else begin
            Mem_RdData <= 32'hA5A5_A5A5;
        end
    end

    // RAM model and monitor, sampled mid-cycle
    always @(negedge Clk) begin
        if (Mem_Enable) begin
            chk("busy_during_access", {63'd0, Busy}, 64'd1);
            if (exp_acc.size() == 0) begin
                chk("unexpected_access", {56'd0, Mem_Address}, 64'hFFFF);
            end else begin
                a = exp_acc.pop_front();
                chk("acc_op", {62'd0, Mem_Op}, {62'd0, a.op});
                chk("acc_addr", {56'd0, Mem_Address}, {56'd0, a.addr});
                if (a.op != 2'b00) chk("acc_wrdata", {32'd0, Mem_WrData}, {32'd0, a.data});
            end
            wbase = {Mem_Address[7:2], 2'b00};
            case (Mem_Op)
                2'b00: begin
                    rd_pend = {mem[wbase], mem[wbase + 8'd1], mem[wbase + 8'd2], mem[wbase + 8'd3]};
                    rd_arm = 1'b1;
                end
                2'b01: mem[Mem_Address] = Mem_WrData[7:0];
                2'b10: begin
                    mem[Mem_Address]        = Mem_WrData[15:8];
                    mem[Mem_Address + 8'd1] = Mem_WrData[7:0];
                end
                default: begin
                    mem[Mem_Address]        = Mem_WrData[31:24];
                    mem[Mem_Address + 8'd1] = Mem_WrData[23:16];
                    mem[Mem_Address + 8'd2] = Mem_WrData[15:8];
                    mem[Mem_Address + 8'd3] = Mem_WrData[7:0];
                end
            endcase
        end
        if (Done) begin
            done_cnt++;
            if (exp_res.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                r = exp_res.pop_front();
                chk("trap", {63'd0, Trap}, {63'd0, r.trap});
                chk("latency", 64'(cyc - e0 + 1), {56'd0, r.lat});
                if (r.chk_data) chk("load_data", LoadData, r.data);
            end
        end
    end

    task automatic put_word(input logic [7:0] ad, input logic [31:0] w);
        mem[ad] = w[31:24]; mem[ad + 8'd1] = w[23:16];
        mem[ad + 8'd2] = w[15:8]; mem[ad + 8'd3] = w[7:0];
    endtask

    task automatic ea(input logic [1:0] op, input logic [7:0] ad, input logic [31:0] d);
        exp_acc.push_back('{op: op, addr: ad, data: d});
    endtask

    task automatic er(input logic [63:0] d, input logic t, input logic [7:0] lat, input logic cd);
        exp_res.push_back('{data: d, trap: t, lat: lat, chk_data: cd});
    endtask

    task automatic launch(input logic [3:0] op, input logic [7:0] ad, input logic [63:0] sd);
        @(negedge Clk);
        CpuOp = op; Address = ad; StoreData = sd; Start = 1'b1;
        @(posedge Clk);
        #1;
        e0 = cyc;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20 && done_cnt < target; i++) begin
            @(negedge Clk);
            #1;
        end
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic req(input logic [3:0] op, input logic [7:0] ad, input logic [63:0] sd);
        int tgt;
        tgt = done_cnt + 1;
        launch(op, ad, sd);
        wait_done(tgt);
    endtask

    task automatic chk_reset_vals();
        chk("rst_loaddata", LoadData, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_trap", {63'd0, Trap}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_mem_enable", {63'd0, Mem_Enable}, 64'd0);
        chk("rst_mem_op", {62'd0, Mem_Op}, 64'd0);
        chk("rst_mem_address", {56'd0, Mem_Address}, 64'd0);
        chk("rst_mem_wrdata", {32'd0, Mem_WrData}, 64'd0);
    endtask

    initial begin
        int tgt;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        put_word(8'h10, 32'h12F4_5678);
        put_word(8'h20, 32'hAAAA_8001);
        put_word(8'h30, 32'hDEAD_BEEF);

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk_reset_vals();

        ea(2'b00, 8'h10, 0); er(64'h0000_0000_FFFF_FFF4, 0, 3, 1); req(4'd0, 8'h11, 64'd0);
        ea(2'b00, 8'h20, 0); er(64'h0000_0000_0000_8001, 0, 3, 1); req(4'd3, 8'h22, 64'd0);
        ea(2'b00, 8'h20, 0); er(64'h0000_0000_FFFF_8001, 0, 3, 1); req(4'd1, 8'h22, 64'd0);

        ea(2'b11, 8'h40, 32'h1122_3344); ea(2'b11, 8'h44, 32'h5566_7788);
        er(64'd0, 0, 3, 0); req(4'd9, 8'h40, 64'h1122_3344_5566_7788);
        ea(2'b00, 8'h40, 0); ea(2'b00, 8'h44, 0);
        er(64'h1122_3344_5566_7788, 0, 5, 1); req(4'd5, 8'h40, 64'd0);

        ea(2'b00, 8'h30, 0); ea(2'b11, 8'h30, 32'h0BAD_F00D);
        er(64'h0000_0000_DEAD_BEEF, 0, 4, 1); req(4'd11, 8'h30, 64'hFFFF_FFFF_0BAD_F00D);
        ea(2'b00, 8'h30, 0); ea(2'b01, 8'h31, 32'h0000_00FF);
        er(64'h0000_0000_0000_00AD, 0, 4, 1); req(4'd10, 8'h31, 64'd0);
        ea(2'b00, 8'h30, 0); er(64'h0000_0000_0BFF_F00D, 0, 3, 1); req(4'd4, 8'h30, 64'd0);

        er(64'd0, 1, 1, 1); req(4'd4, 8'h06, 64'd0);
        er(64'd0, 1, 1, 1); req(4'd5, 8'h04, 64'd0);
        er(64'd0, 1, 1, 1); req(4'd13, 8'h00, 64'd0);
        er(64'd0, 1, 1, 1); req(4'd7, 8'h13, 64'd0);

        ea(2'b01, 8'h13, 32'h0000_00AB); er(64'd0, 0, 2, 0); req(4'd6, 8'h13, 64'hFFFF_FFFF_1234_56AB);
        ea(2'b00, 8'h10, 0); er(64'h0000_0000_0000_00AB, 0, 3, 1); req(4'd2, 8'h13, 64'd0);
        ea(2'b10, 8'h16, 32'h0000_BEEF); er(64'd0, 0, 2, 0); req(4'd7, 8'h16, 64'hFFFF_FFFF_FFFF_BEEF);
        ea(2'b00, 8'h14, 0); er(64'h0000_0000_FFFF_BEEF, 0, 3, 1); req(4'd1, 8'h16, 64'd0);
        ea(2'b11, 8'h18, 32'hCAFE_F00D); er(64'd0, 0, 2, 0); req(4'd8, 8'h18, 64'h0000_0001_CAFE_F00D);
        ea(2'b00, 8'h18, 0); er(64'h0000_0000_CAFE_F00D, 0, 3, 1); req(4'd4, 8'h18, 64'd0);

        // Reset during CAP1 of an LDD: one read only, no Done.
        ea(2'b00, 8'h40, 0);
        launch(4'd5, 8'h40, 64'd0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        chk_reset_vals();
        repeat (6) @(negedge Clk);

        // A second Start while busy must be dropped.
        tgt = done_cnt + 1;
        ea(2'b00, 8'h10, 0); er(64'h0000_0000_12F4_56AB, 0, 3, 1);
        launch(4'd4, 8'h10, 64'd0);
        CpuOp = 4'd8; Address = 8'h50; StoreData = 64'h0000_0000_DEAD_0000; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        wait_done(tgt);
        repeat (4) @(negedge Clk);

        chk("acc_left", 64'(exp_acc.size()), 64'd0);
        chk("res_left", 64'(exp_res.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
